fsm_010_gen: RTL and testbench

//  Serial stimulus transmitter for the "010" sequence-detector interface: on a

---
 rtl/fsm_010_gen.sv | 159 +++++++++++++++
 tb/tb_fsm_010_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fsm_010_gen.sv
// fsm_010_gen: serial stimulus generator for a "010" sequence detector.
// On an accepted request it emits exactly N non-overlapping "010" patterns.
// Consecutive patterns are separated by G idle '1' bits. The line idles at 1.
// Optional feature: define FSM_GEN_ABORT_EN to add an 'abort' input. When
// abort is high in a busy state, the request is cut short: the FSM goes to FIN
// and only patterns that were fully emitted are counted.
module fsm_010_gen #(
  parameter int CNT_W = 10,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef FSM_GEN_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [CNT_W-1:0] req_count,
  input  logic [GAP_W-1:0] gap_cfg,
  output logic             x,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_B0   = 3'd1,
    S_B1   = 3'd2,
    S_B2   = 3'd3,
    S_GAP  = 3'd4,
    S_FIN  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   n_q, n_d;          // latched pattern count N
  logic [GAP_W-1:0]   g_q, g_d;          // latched gap length G
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]   sent_q, sent_d;
  logic               x_q, x_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept;
  logic               in_busy;
  logic               abort_w;
  logic [CNT_W:0]     sent_inc;          // one bit wider so N = 2**CNT_W-1 compares cleanly
  logic               last_pat;

`ifdef FSM_GEN_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign start_ready = (state_q == S_IDLE);
  assign accept      = start_valid && start_ready;
  assign in_busy     = (state_q == S_B0) || (state_q == S_B1) ||
                       (state_q == S_B2) || (state_q == S_GAP);
  assign sent_inc    = {1'b0, sent_q} + {{CNT_W{1'b0}}, 1'b1};
  assign last_pat    = (sent_inc == {1'b0, n_q});

  // State register plus request/progress registers; reset aborts any request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      g_q       <= '0;
      gap_cnt_q <= '0;
      sent_q    <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      g_q       <= g_d;
      gap_cnt_q <= gap_cnt_d;
      sent_q    <= sent_d;
    end
  end

  // Next-state logic: walk B0->B1->B2, then optionally GAP, until N patterns are done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = (req_count == '0) ? S_FIN : S_B0;
      end
      S_B0:   state_d = S_B1;
      S_B1:   state_d = S_B2;
      S_B2: begin
        if (last_pat)        state_d = S_FIN;
        else if (g_q == '0)  state_d = S_B0;
        else                 state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt_q == '0) state_d = S_B0;
      end
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // An abort overrides normal sequencing. A pattern still in flight is dropped.
    if (abort_w && in_busy) state_d = S_FIN;
  end

  // Datapath next values: latch the request, count finished patterns, run the gap timer.
  always_comb begin
    n_d       = n_q;
    g_d       = g_q;
    gap_cnt_d = gap_cnt_q;
    sent_d    = sent_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          n_d    = req_count;
          g_d    = gap_cfg;
          sent_d = '0;
        end
      end
      S_B2: begin
        // The pattern counts only once its final 0 has been emitted without an abort.
        if (!abort_w) begin
          sent_d = sent_inc[CNT_W-1:0];
          // Load G-1 so the GAP state lasts exactly G cycles.
          if (!last_pat && (g_q != '0)) gap_cnt_d = g_q - 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  // Output decode from the next state, so x/busy/done are registered without extra latency.
  always_comb begin
    x_d    = !((state_d == S_B0) || (state_d == S_B2));
    busy_d = (state_d == S_B0) || (state_d == S_B1) ||
             (state_d == S_B2) || (state_d == S_GAP);
    done_d = (state_d == S_FIN);
  end

  // Output registers; the line idles high on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign x          = x_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sent_count = sent_q;

endmodule

// File: tb/tb_fsm_010_gen.sv
// Bench for fsm_010_gen. The reference is the expected bit stream for each
// request, built directly from N and G. Expected sent_count for each cycle is
// derived from that stream. Observed x is also scanned for "010" hits, the way
// the downstream detector would scan it.
module tb_fsm_010_gen;
  localparam int CNT_W = 10;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             abort = 1'b0;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [CNT_W-1:0] req_count = '0;
  logic [GAP_W-1:0] gap_cfg = '0;
  logic             x, busy, done;
  logic [CNT_W-1:0] sent_count;

  int checks = 0;
  int failures = 0;

  bit exp_x[$];
  int exp_sc[$];

  fsm_010_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk(clk),
    .rst(rst),
`ifdef FSM_GEN_ABORT_EN
    .abort(abort),
`endif
    .start_valid(start_valid),
    .start_ready(start_ready),
    .req_count(req_count),
    .gap_cfg(gap_cfg),
    .x(x),
    .busy(busy),
    .done(done),
    .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Expected stream: N copies of 010, with G ones between copies and none after the last.
  task automatic build_model(input int n, input int g);
    exp_x.delete();
    exp_sc.delete();
    for (int i = 0; i < n; i++) begin
      exp_x.push_back(1'b0); exp_sc.push_back(i);
      exp_x.push_back(1'b1); exp_sc.push_back(i);
      exp_x.push_back(1'b0); exp_sc.push_back(i);
      if (i < n - 1)
        for (int j = 0; j < g; j++) begin
          exp_x.push_back(1'b1); exp_sc.push_back(i + 1);
        end
    end
  endtask

  // Wait for the generator to return to idle, with a bounded wait.
  task automatic wait_ready();
    for (int i = 0; i < 64 && start_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (start_ready !== 1'b1) begin
      failures++;
      $display("FAIL wait_ready: start_ready=%b want 1", start_ready);
    end
  endtask

  // Issue one request and check every cycle until idle, or stop at stream index stop_at.
  task automatic run_req(input int n, input int g, input bit hold, input int stop_at);
    bit obs[$];
    int hits;
    int i;
    wait_ready();
    start_valid = 1'b1;
    req_count   = n[CNT_W-1:0];
    gap_cfg     = g[GAP_W-1:0];
    @(posedge clk); #1;
    if (!hold) start_valid = 1'b0;
    // Changes after accept must not matter.
    req_count = CNT_W'($urandom);
    gap_cfg   = GAP_W'($urandom);
    build_model(n, g);
    for (int k = 0; k < exp_x.size(); k++) begin
      checks++;
      if (x !== exp_x[k] || busy !== 1'b1 || done !== 1'b0 || start_ready !== 1'b0 ||
          sent_count !== exp_sc[k][CNT_W-1:0]) begin
        failures++;
        $display("FAIL stream n=%0d g=%0d k=%0d: x=%b busy=%b done=%b rdy=%b sent=%0d want x=%b busy=1 done=0 rdy=0 sent=%0d",
                 n, g, k, x, busy, done, start_ready, sent_count, exp_x[k], exp_sc[k]);
      end
      obs.push_back(x);
      if (k == stop_at) return;
      @(posedge clk); #1;
    end
    checks++;
    if (done !== 1'b1 || x !== 1'b1 || busy !== 1'b0 || start_ready !== 1'b0 ||
        sent_count !== n[CNT_W-1:0]) begin
      failures++;
      $display("FAIL fin n=%0d g=%0d: done=%b x=%b busy=%b rdy=%b sent=%0d want done=1 x=1 busy=0 rdy=0 sent=%0d",
               n, g, done, x, busy, start_ready, sent_count, n);
    end
    hits = 0;
    i = 0;
    while (i + 2 < obs.size()) begin
      if (obs[i] == 1'b0 && obs[i+1] == 1'b1 && obs[i+2] == 1'b0) begin
        hits++; i += 3;
      end else i++;
    end
    checks++;
    if (hits != n) begin
      failures++;
      $display("FAIL detector n=%0d g=%0d: hits=%0d want %0d", n, g, hits, n);
    end
    @(posedge clk); #1;
    if (hold) start_valid = 1'b0;
    checks++;
    if (done !== 1'b0 || start_ready !== 1'b1 || x !== 1'b1 || busy !== 1'b0 ||
        sent_count !== n[CNT_W-1:0]) begin
      failures++;
      $display("FAIL idle n=%0d: done=%b rdy=%b x=%b busy=%b sent=%0d want done=0 rdy=1 x=1 busy=0 sent=%0d",
               n, done, start_ready, x, busy, sent_count, n);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (x !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || sent_count !== '0 || start_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset: x=%b busy=%b done=%b sent=%0d rdy=%b want 1 0 0 0 1",
               x, busy, done, sent_count, start_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    run_req(1, 0, 1'b0, -1);
  endtask

  task automatic test_gap();
    run_req(3, 2, 1'b0, -1);
  endtask

  task automatic test_zero();
    run_req(0, 5, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++)
      run_req(int'($urandom_range(0, 20)), int'($urandom_range(0, 15)),
              1'b1 & $urandom_range(0, 1), -1);
  endtask

  task automatic test_reset_mid();
    int g;
    g = int'($urandom_range(0, 3));
    // Stop in the B1 cycle of the second pattern.
    run_req(5, g, 1'b0, 3 + g + 1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (x !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || sent_count !== '0 || start_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid: x=%b busy=%b done=%b sent=%0d rdy=%b want 1 0 0 0 1",
               x, busy, done, sent_count, start_ready);
    end
    #1 rst = 1'b0;
    start_valid = 1'b1;
    req_count   = 10'd2;
    gap_cfg     = 4'd0;
    @(posedge clk); #1;
    start_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || x !== 1'b0 || sent_count !== '0) begin
      failures++;
      $display("FAIL reset_mid_accept: busy=%b x=%b sent=%0d want busy=1 x=0 sent=0",
               busy, x, sent_count);
    end
    wait_ready();
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    run_req(1023, 0, 1'b1, -1);
    run_req(2, 1, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_gap();
    test_zero();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
